axis_stall_watchdog: RTL and testbench
======================================

// Module: axis_stall_watchdog
// PURPOSE
//  Cycle-accurate stall/deadlock detector used in the co-simulation harness of the
//  hyperspectral_hw_wrapped kernel. It consumes the per-channel AXIS blocking flags,
//  per-instance idle flags and instance-level block flags gathered by the kernel
//  monitor top. It debounces them with persistence counters and raises a sticky
//  kernel-block flag, together with which channel(s) caused it.
// PARAMETERS
//  N_CH    5    number of AXIS channels; also number of idle flags (index i pairs with i)
//  N_BLK   1    number of instance-level block flags
//  THRESH  16   consecutive qualified-stall cycles before a channel counts as stuck (1..255)
// PORTS
//  ap_clk            in   1      kernel clock, all logic on rising edge
//  ap_rst_n          in   1      asynchronous active-low reset
//  axis_block_sigs   in   N_CH   1 = channel i stalled (TDATA_blk_n inverted)
//  inst_idle_sigs    in   N_CH   1 = owning instance of channel i is idle
//  inst_block_sigs   in   N_BLK  1 = instance reports internal block
//  clear             in   1      synchronous clear of sticky state
//  block             out  1      sticky kernel-block flag
//  block_pulse       out  1      one-cycle pulse on entry to BLOCKED
//  first_block_ch    out  N_CH   one-hot(s) of channels stuck at BLOCKED entry
//  stall_cycles      out  32     cycles spent in SUSPECT/BLOCKED since last MONITOR
// BEHAVIOUR
//  - Reset (async, ap_rst_n=0): state=MONITOR; block, block_pulse=0; first_block_ch=0;
//    stall_cycles=0; all channel counters=0. Reset mid-operation aborts immediately.
//  - Qualified stall q[i] = axis_block_sigs[i] & ~inst_idle_sigs[i].
//  - Per-channel counter cnt[i] (8 bit): q[i]=1 -> cnt+1, saturating at THRESH; q[i]=0 -> 0.
//    stuck_nxt[i] = (cnt_next[i]==THRESH).
//  - ib = |inst_block_sigs, sampled directly (no debounce).
//  - FSM, evaluated each edge; clear has priority over every transition:
//    MONITOR: |q -> SUSPECT; ib -> BLOCKED (ib wins if both).
//    SUSPECT: |stuck_nxt or ib -> BLOCKED; else ~|q -> MONITOR; else stay.
//    BLOCKED: sticky; only clear (-> MONITOR) or reset leaves.
//    clear=1 in any state: next state MONITOR, all cnt=0, first_block_ch=0,
//    stall_cycles=0, block=0. Inputs in the same cycle are ignored and re-evaluated next edge.
//  - Latency: continuous q[i] from cycle 1 -> block=1 after edge THRESH
//    (THRESH edges after q first sampled). ib -> block=1 after 1 edge.
//  - block = (state==BLOCKED), registered. block_pulse=1 exactly on the cycle after the
//    entering edge, and only once per entry.
//  - first_block_ch <= stuck_nxt on the entering edge (several bits if simultaneous;
//    all-zero if entry was caused only by ib). Held until clear/reset.
//  - stall_cycles: +1 per edge while state is SUSPECT or BLOCKED, saturating at
//    32'hFFFF_FFFF. Zeroed on entry to MONITOR.
//  - Counters keep running in BLOCKED; they do not alter first_block_ch.
//  - Short stalls (< THRESH cycles) then release: return to MONITOR, no block.
//  - X on inputs while ap_rst_n=0 must not propagate to outputs.
// TESTING
//  1 Reset: ap_rst_n=0 mid-BLOCKED -> same cycle block=0, first_block_ch=0, stall_cycles=0.
//  2 q[2] high for 16 cycles (THRESH=16), others 0 -> block=1 after edge 16,
//    block_pulse one cycle, first_block_ch=5'b00100.
//  3 axis_block_sigs[1]=1 with inst_idle_sigs[1]=1 for 100 cycles -> block stays 0,
//    state MONITOR.
//  4 q[3] high 10 cycles, low 1, high 10 -> no block; stall_cycles returns to 0.
//  5 q[0],q[4] rise together for 16 cycles -> first_block_ch=5'b10001; then
//    clear=1 with inst_block_sigs=1 same cycle -> block=0, next edge block=1,
//    first_block_ch=0.
//  6 Force stall_cycles near 32'hFFFF_FFFE in BLOCKED -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/axis_stall_watchdog.sv
// Stall/deadlock watchdog for AXIS channels: debounces qualified stalls per channel
// and latches a sticky kernel-block flag with the channel(s) that caused it.
module axis_stall_watchdog #(
    parameter int N_CH   = 5,
    parameter int N_BLK  = 1,
    parameter int THRESH = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [N_CH-1:0]   axis_block_sigs,
    input  logic [N_CH-1:0]   inst_idle_sigs,
    input  logic [N_BLK-1:0]  inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_pulse,
    output logic [N_CH-1:0]   first_block_ch,
    output logic [31:0]       stall_cycles
);

    localparam logic [7:0] THRESH_C = 8'(THRESH);

    typedef enum logic [1:0] {
        ST_MONITOR,
        ST_SUSPECT,
        ST_BLOCKED
    } state_t;

    state_t            r_state;
    logic              r_block;
    logic              r_block_pulse;
    logic [N_CH-1:0]   r_first_block_ch;
    logic [31:0]       r_stall_cycles;
    logic [7:0]        r_cnt      [N_CH];
    logic [7:0]        w_cnt_next [N_CH];
    logic [N_CH-1:0]   w_q;
    logic [N_CH-1:0]   w_stuck_nxt;
    logic              w_ib;
    logic              w_any_q;
    logic              w_any_stuck;
    logic [31:0]       w_stall_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign w_q[gi] = axis_block_sigs[gi] & ~inst_idle_sigs[gi];

            // Counter saturates at THRESH so a channel stays "stuck" while its stall persists.
            always_comb begin
                w_cnt_next[gi] = 8'd0;
                if (!clear && w_q[gi])
                    w_cnt_next[gi] = (r_cnt[gi] == THRESH_C) ? THRESH_C : r_cnt[gi] + 8'd1;
            end

            assign w_stuck_nxt[gi] = (w_cnt_next[gi] == THRESH_C);

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n)
                    r_cnt[gi] <= 8'd0;
                else
                    r_cnt[gi] <= w_cnt_next[gi];
            end
        end
    endgenerate

    assign w_ib        = |inst_block_sigs;
    assign w_any_q     = |w_q;
    assign w_any_stuck = |w_stuck_nxt;
    assign w_stall_inc = (r_stall_cycles == 32'hFFFF_FFFF) ? r_stall_cycles : r_stall_cycles + 32'd1;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state          <= ST_MONITOR;
            r_block          <= 1'b0;
            r_block_pulse    <= 1'b0;
            r_first_block_ch <= '0;
            r_stall_cycles   <= 32'd0;
        end else if (clear) begin
            r_state          <= ST_MONITOR;
            r_block          <= 1'b0;
            r_block_pulse    <= 1'b0;
            r_first_block_ch <= '0;
            r_stall_cycles   <= 32'd0;
        end else begin
            r_block_pulse <= 1'b0;
            case (r_state)
                ST_MONITOR: begin
                    if (w_ib) begin
                        r_state          <= ST_BLOCKED;
                        r_block          <= 1'b1;
                        r_block_pulse    <= 1'b1;
                        r_first_block_ch <= w_stuck_nxt;
                    end else if (w_any_q) begin
                        r_state <= ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (w_any_stuck || w_ib) begin
                        r_state          <= ST_BLOCKED;
                        r_block          <= 1'b1;
                        r_block_pulse    <= 1'b1;
                        r_first_block_ch <= w_stuck_nxt;
                        r_stall_cycles   <= w_stall_inc;
                    end else if (!w_any_q) begin
                        r_state        <= ST_MONITOR;
                        r_stall_cycles <= 32'd0;
                    end else begin
                        r_stall_cycles <= w_stall_inc;
                    end
                end
                ST_BLOCKED: begin
                    r_stall_cycles <= w_stall_inc;
                end
                default: begin
                    r_state        <= ST_MONITOR;
                    r_block        <= 1'b0;
                    r_stall_cycles <= 32'd0;
                end
            endcase
        end
    end

    assign block          = r_block;
    assign block_pulse    = r_block_pulse;
    assign first_block_ch = r_first_block_ch;
    assign stall_cycles   = r_stall_cycles;

endmodule

// File: tb/tb_axis_stall_watchdog.sv
// Directed plus randomized bench for axis_stall_watchdog, checked against a
// cycle-level behavioural model of the watchdog rules.
module tb_axis_stall_watchdog;

    localparam int N_CH   = 5;
    localparam int N_BLK  = 1;
    localparam int THRESH = 16;
    localparam int M_MON  = 0;
    localparam int M_SUS  = 1;
    localparam int M_BLK  = 2;
    localparam longint STALL_MAX = 64'h0000_0000_FFFF_FFFF;

    logic              ap_clk;
    logic              ap_rst_n;
    logic [N_CH-1:0]   axis_block_sigs;
    logic [N_CH-1:0]   inst_idle_sigs;
    logic [N_BLK-1:0]  inst_block_sigs;
    logic              clear;
    logic              block;
    logic              block_pulse;
    logic [N_CH-1:0]   first_block_ch;
    logic [31:0]       stall_cycles;

    axis_stall_watchdog #(.N_CH(N_CH), .N_BLK(N_BLK), .THRESH(THRESH)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .clear           (clear),
        .block           (block),
        .block_pulse     (block_pulse),
        .first_block_ch  (first_block_ch),
        .stall_cycles    (stall_cycles)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    string cur_step = "init";

    // Reference model: run length of each channel's qualified stall, mode, outputs.
    int              run_len [N_CH];
    int              m_mode;
    logic            m_block;
    logic            m_pulse;
    logic [N_CH-1:0] m_fbc;
    longint          m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", cur_step, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) run_len[i] = 0;
        m_mode  = M_MON;
        m_block = 1'b0;
        m_pulse = 1'b0;
        m_fbc   = '0;
        m_stall = 0;
    endtask

    task automatic model_step(input logic [N_CH-1:0] ax, input logic [N_CH-1:0] idl,
                              input logic ibv, input logic clr);
        int              nxt;
        logic [N_CH-1:0] stuck;
        bit              any_q;
        if (clr) begin
            model_reset();
            return;
        end
        stuck = '0;
        any_q = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ax[i] && !idl[i]) begin
                any_q = 1'b1;
                run_len[i] = (run_len[i] < THRESH) ? run_len[i] + 1 : THRESH;
            end else begin
                run_len[i] = 0;
            end
            stuck[i] = (run_len[i] == THRESH);
        end
        nxt = m_mode;
        if (m_mode == M_MON)
            nxt = ibv ? M_BLK : (any_q ? M_SUS : M_MON);
        else if (m_mode == M_SUS)
            nxt = ((|stuck) || ibv) ? M_BLK : (!any_q ? M_MON : M_SUS);
        m_pulse = (m_mode != M_BLK) && (nxt == M_BLK);
        if (m_pulse) m_fbc = stuck;
        if (nxt == M_MON)
            m_stall = 0;
        else if (m_mode != M_MON && m_stall < STALL_MAX)
            m_stall = m_stall + 1;
        m_mode  = nxt;
        m_block = (nxt == M_BLK);
    endtask

    task automatic check_model();
        chk("block",          32'(block),          32'(m_block));
        chk("block_pulse",    32'(block_pulse),    32'(m_pulse));
        chk("first_block_ch", 32'(first_block_ch), 32'(m_fbc));
        chk("stall_cycles",   stall_cycles,        m_stall[31:0]);
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare 1 ns later.
    task automatic cyc(input logic [N_CH-1:0] ax, input logic [N_CH-1:0] idl,
                       input logic ibv, input logic clr);
        axis_block_sigs = ax;
        inst_idle_sigs  = idl;
        inst_block_sigs = ibv;
        clear           = clr;
        @(posedge ap_clk);
        model_step(ax, idl, ibv, clr);
        #1;
        check_model();
    endtask

    initial begin
        logic [N_CH-1:0] rax;
        logic [N_CH-1:0] ridl;
        logic            rib;
        logic            rclr;

        // Reset with X on every input must still yield clean outputs.
        cur_step        = "reset";
        ap_rst_n        = 1'b0;
        axis_block_sigs = 'x;
        inst_idle_sigs  = 'x;
        inst_block_sigs = 'x;
        clear           = 1'bx;
        model_reset();
        repeat (3) @(posedge ap_clk);
        #1;
        check_model();
        axis_block_sigs = '0;
        inst_idle_sigs  = '0;
        inst_block_sigs = '0;
        clear           = 1'b0;
        #2 ap_rst_n = 1'b1;
        cyc('0, '0, 1'b0, 1'b0);

        // Single channel stuck for exactly THRESH cycles.
        cur_step = "single_ch";
        for (int k = 1; k <= THRESH; k++) begin
            cyc(5'b00100, '0, 1'b0, 1'b0);
            chk("block_at_edge", 32'(block), (k == THRESH) ? 32'd1 : 32'd0);
        end
        chk("pulse_on_entry", 32'(block_pulse), 32'd1);
        chk("fbc_ch2", 32'(first_block_ch), 32'b00100);
        cyc('0, '0, 1'b0, 1'b0);
        chk("pulse_once", 32'(block_pulse), 32'd0);
        chk("block_sticky", 32'(block), 32'd1);
        chk("stall_after", stall_cycles, 32'd16);
        cyc('0, '0, 1'b0, 1'b1);
        chk("clear_block", 32'(block), 32'd0);

        // Blocked-but-idle channel is not a qualified stall.
        cur_step = "idle_masked";
        for (int k = 0; k < 100; k++) cyc(5'b00010, 5'b00010, 1'b0, 1'b0);
        chk("idle_no_block", 32'(block), 32'd0);
        chk("idle_stall0", stall_cycles, 32'd0);

        // Short stalls interrupted by one free cycle.
        cur_step = "short_stalls";
        for (int k = 0; k < 10; k++) cyc(5'b01000, '0, 1'b0, 1'b0);
        chk("short_stall_cnt", stall_cycles, 32'd9);
        cyc('0, '0, 1'b0, 1'b0);
        chk("short_back_mon", stall_cycles, 32'd0);
        for (int k = 0; k < 10; k++) cyc(5'b01000, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        chk("short_no_block", 32'(block), 32'd0);
        chk("short_stall0", stall_cycles, 32'd0);

        // Two channels reach threshold together, then clear racing an instance block.
        cur_step = "dual_ch";
        for (int k = 0; k < THRESH; k++) cyc(5'b10001, '0, 1'b0, 1'b0);
        chk("dual_block", 32'(block), 32'd1);
        chk("dual_fbc", 32'(first_block_ch), 32'b10001);
        cyc('0, '0, 1'b1, 1'b1);
        chk("clr_wins_block", 32'(block), 32'd0);
        chk("clr_wins_fbc", 32'(first_block_ch), 32'd0);
        cyc('0, '0, 1'b1, 1'b0);
        chk("ib_block", 32'(block), 32'd1);
        chk("ib_fbc_zero", 32'(first_block_ch), 32'd0);
        chk("ib_pulse", 32'(block_pulse), 32'd1);

        // Saturation of the stall counter while blocked.
        cur_step = "saturate";
        cyc('0, '0, 1'b0, 1'b0);
        force dut.r_stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cycles;
        m_stall = 64'h0000_0000_FFFF_FFFE;
        cyc('0, '0, 1'b0, 1'b0);
        chk("sat_reach", stall_cycles, 32'hFFFF_FFFF);
        cyc('0, '0, 1'b0, 1'b0);
        chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
        cyc('0, '0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        cur_step = "random";
        rax  = '0;
        ridl = '0;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 9) == 0)  rax[i]  = ~rax[i];
                if ($urandom_range(0, 29) == 0) ridl[i] = ~ridl[i];
            end
            rib  = ($urandom_range(0, 99) < 2);
            rclr = ($urandom_range(0, 99) < 3);
            cyc(rax, ridl, rib, rclr);
        end

        // Asynchronous reset in the middle of BLOCKED.
        cur_step = "async_reset";
        cyc('0, '0, 1'b1, 1'b0);
        cyc(5'b00001, '0, 1'b0, 1'b0);
        chk("pre_reset_block", 32'(block), 32'd1);
        #2 ap_rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        axis_block_sigs = 'x;
        inst_idle_sigs  = 'x;
        inst_block_sigs = 'x;
        clear           = 1'bx;
        repeat (2) @(posedge ap_clk);
        #1;
        check_model();
        axis_block_sigs = '0;
        inst_idle_sigs  = '0;
        inst_block_sigs = '0;
        clear           = 1'b0;
        #2 ap_rst_n = 1'b1;
        cyc('0, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
